// File: rtl/barrier_state_lut.sv
// Associative communicator-ID -> barrier-state table with parallel compare, release and occupancy tracking.
// Optional saturating hit/miss/full counters are enabled by defining BARRIER_LUT_STATS_EN.

module barrier_lut_cmp #(
    parameter int KEY_WIDTH = 16
) (
    input  logic                 valid,
    input  logic [KEY_WIDTH-1:0] entry_key,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 match,
    output logic                 free
);
    assign match = valid && (entry_key == key);
    assign free  = !valid;
endmodule

module barrier_state_lut #(
    parameter int KEY_WIDTH      = 16,
    parameter int STATE_WIDTH    = 3,
    parameter int LUT_DEPTH_BITS = 4,
    parameter int LUT_DEPTH      = 2**LUT_DEPTH_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lookup_req,
    input  logic [KEY_WIDTH-1:0]      lookup_key,
    input  logic [STATE_WIDTH-1:0]    state_in,
    output logic                      lookup_ack,
    output logic [STATE_WIDTH-1:0]    state_out,
    output logic                      lut_hit,
    output logic                      lut_miss,
    output logic                      lut_full,
    output logic                      ready,
`ifdef BARRIER_LUT_STATS_EN
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
    output logic [31:0]               full_count,
`endif
    output logic [LUT_DEPTH_BITS:0]   occupancy
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_COMPARE, S_RESOLVE} state_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [STATE_WIDTH-1:0] st;
    } req_t;

    typedef struct packed {
        logic                      match;
        logic [LUT_DEPTH_BITS-1:0] match_idx;
        logic                      free;
        logic [LUT_DEPTH_BITS-1:0] free_idx;
    } cmp_t;

    localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX = LUT_DEPTH_BITS'(LUT_DEPTH - 1);
    localparam logic [LUT_DEPTH_BITS:0]   OCC_MAX  = (LUT_DEPTH_BITS + 1)'(LUT_DEPTH);
    localparam logic [STATE_WIDTH-1:0]    ST_REL   = {STATE_WIDTH{1'b1}};

    state_t state_q, state_d;
    req_t   req_q;
    cmp_t   cmp_q, cmp_d;

    logic [LUT_DEPTH_BITS-1:0]                 init_idx;
    logic [LUT_DEPTH-1:0][KEY_WIDTH-1:0]       key_mem;
    logic [LUT_DEPTH-1:0][STATE_WIDTH-1:0]     state_mem;
    logic [LUT_DEPTH-1:0]                      valid;
    logic [LUT_DEPTH-1:0]                      match_vec;
    logic [LUT_DEPTH-1:0]                      free_vec;

    logic accept, in_resolve, is_read, is_rel, is_write;
    logic do_update, do_alloc, do_release, do_full;
    logic [STATE_WIDTH-1:0] stored_st;

    genvar g;
    generate
        for (g = 0; g < LUT_DEPTH; g++) begin : g_cmp
            barrier_lut_cmp #(.KEY_WIDTH(KEY_WIDTH)) u_cmp (
                .valid     (valid[g]),
                .entry_key (key_mem[g]),
                .key       (req_q.key),
                .match     (match_vec[g]),
                .free      (free_vec[g])
            );
        end
    endgenerate

    // Scanning from the top down leaves the lowest set index in each encoder.
    always_comb begin
        cmp_d = '0;
        for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                cmp_d.match     = 1'b1;
                cmp_d.match_idx = LUT_DEPTH_BITS'(i);
            end
            if (free_vec[i]) begin
                cmp_d.free     = 1'b1;
                cmp_d.free_idx = LUT_DEPTH_BITS'(i);
            end
        end
    end

    assign accept     = (state_q == S_IDLE) && lookup_req && !lookup_ack && ready;
    assign in_resolve = (state_q == S_RESOLVE);
    assign is_read    = (req_q.st == '0);
    assign is_rel     = (req_q.st == ST_REL);
    assign is_write   = !is_read && !is_rel;
    assign stored_st  = state_mem[cmp_q.match_idx];

    assign do_update  = in_resolve && cmp_q.match && is_write && (stored_st != req_q.st);
    assign do_release = in_resolve && cmp_q.match && is_rel;
    assign do_alloc   = in_resolve && !cmp_q.match && is_write && cmp_q.free;
    assign do_full    = in_resolve && !cmp_q.match && is_write && !cmp_q.free;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (init_idx == LAST_IDX) state_d = S_IDLE;
            S_IDLE:    if (accept) state_d = S_COMPARE;
            S_COMPARE: state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx   <= '0;
            ready      <= 1'b0;
            req_q      <= '0;
            cmp_q      <= '0;
            lookup_ack <= 1'b0;
            state_out  <= '0;
            lut_hit    <= 1'b0;
            lut_miss   <= 1'b0;
            lut_full   <= 1'b0;
            occupancy  <= '0;
        end else begin
            lut_hit  <= 1'b0;
            lut_miss <= 1'b0;
            lut_full <= 1'b0;
            if (state_q == S_INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == LAST_IDX) ready <= 1'b1;
            end
            if (accept) req_q <= '{key: lookup_key, st: state_in};
            if (state_q == S_COMPARE) cmp_q <= cmp_d;
            if (in_resolve) begin
                lookup_ack <= 1'b1;
                lut_hit    <= cmp_q.match;
                lut_miss   <= !cmp_q.match;
                lut_full   <= do_full;
                state_out  <= cmp_q.match ? stored_st : '0;
            end else if (!lookup_req) begin
                lookup_ack <= 1'b0;
            end
            if (do_alloc && occupancy < OCC_MAX)
                occupancy <= occupancy + 1'b1;
            else if (do_release && occupancy != '0)
                occupancy <= occupancy - 1'b1;
        end
    end

    // Table storage; only the valid bits need clearing, done by the INIT sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_INIT) valid[init_idx] <= 1'b0;
            if (do_release) valid[cmp_q.match_idx] <= 1'b0;
            if (do_update) state_mem[cmp_q.match_idx] <= req_q.st;
            if (do_alloc) begin
                valid[cmp_q.free_idx]     <= 1'b1;
                key_mem[cmp_q.free_idx]   <= req_q.key;
                state_mem[cmp_q.free_idx] <= req_q.st;
            end
        end
    end

`ifdef BARRIER_LUT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            full_count <= '0;
        end else begin
            if (lut_hit  && hit_count  != '1) hit_count  <= hit_count  + 1'b1;
            if (lut_miss && miss_count != '1) miss_count <= miss_count + 1'b1;
            if (lut_full && full_count != '1) full_count <= full_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_barrier_state_lut.sv
// Directed, table-driven bench for barrier_state_lut: sweep, allocate/update/release, full table, handshake, reset mid-lookup.

module tb_barrier_state_lut;
    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_req;
    logic [15:0] lookup_key;
    logic [2:0]  state_in;
    logic        lookup_ack;
    logic [2:0]  state_out;
    logic        lut_hit, lut_miss, lut_full, ready;
    logic [4:0]  occupancy;
`ifdef BARRIER_LUT_STATS_EN
    logic [31:0] hit_count, miss_count, full_count;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    barrier_state_lut dut (
        .clk        (clk),
        .reset      (reset),
        .lookup_req (lookup_req),
        .lookup_key (lookup_key),
        .state_in   (state_in),
        .lookup_ack (lookup_ack),
        .state_out  (state_out),
        .lut_hit    (lut_hit),
        .lut_miss   (lut_miss),
        .lut_full   (lut_full),
        .ready      (ready),
`ifdef BARRIER_LUT_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .full_count (full_count),
`endif
        .occupancy  (occupancy)
    );

    typedef struct {
        logic [15:0] key;
        logic [2:0]  st;
        logic        hit;
        logic        miss;
        logic        full;
        logic [2:0]  so;
        logic [4:0]  occ;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [15:0] k, input logic [2:0] s, input logic h,
                                input logic m, input logic f, input logic [2:0] so, input logic [4:0] occ);
        vec_t v;
        v.key = k; v.st = s; v.hit = h; v.miss = m; v.full = f; v.so = so; v.occ = occ;
        return v;
    endfunction

    // One full handshake; returns outputs sampled in the cycle lookup_ack first rises.
    task automatic do_lookup(input logic [15:0] k, input logic [2:0] s, input string tag,
                             output logic [7:0] flags, output int lat);
        int cyc = 0;
        @(negedge clk);
        lookup_req = 1'b1; lookup_key = k; state_in = s;
        do begin
            @(negedge clk);
            cyc++;
        end while (!lookup_ack && cyc < 20);
        if (!lookup_ack) check({tag, " ack_timeout"}, 32'(lookup_ack), 32'd1);
        flags = {lut_hit, lut_miss, lut_full, state_out, 2'b00};
        lat = cyc - 1;
        lookup_req = 1'b0;
        @(negedge clk);
        check({tag, " ack_clear"}, 32'(lookup_ack), 32'd0);
    endtask

    initial begin
        logic [7:0] fl;
        int lat;
        int cnt;
        int pulses;

        reset = 1'b1; lookup_req = 1'b0; lookup_key = '0; state_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {lookup_ack, lut_hit, lut_miss, lut_full, ready, state_out, occupancy}, 32'd0);
        reset = 1'b0;

        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ready && cnt < 40);
        check("sweep_cycles", cnt, 16);

        vecs.push_back(mk(16'h0042, 3'd0, 0, 1, 0, 3'd0, 5'd0));
        vecs.push_back(mk(16'h0042, 3'd3, 0, 1, 0, 3'd0, 5'd1));
        vecs.push_back(mk(16'h0042, 3'd0, 1, 0, 0, 3'd3, 5'd1));
        vecs.push_back(mk(16'h0042, 3'd5, 1, 0, 0, 3'd3, 5'd1));
        vecs.push_back(mk(16'h0042, 3'd0, 1, 0, 0, 3'd5, 5'd1));
        vecs.push_back(mk(16'h0042, 3'd7, 1, 0, 0, 3'd5, 5'd0));
        vecs.push_back(mk(16'h0042, 3'd0, 0, 1, 0, 3'd0, 5'd0));
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(16'(i), 3'd1, 0, 1, 0, 3'd0, 5'(i)));
        vecs.push_back(mk(16'h0099, 3'd2, 0, 1, 1, 3'd0, 5'd16));
        vecs.push_back(mk(16'h0099, 3'd0, 0, 1, 0, 3'd0, 5'd16));
        vecs.push_back(mk(16'h0005, 3'd7, 1, 0, 0, 3'd1, 5'd15));
        vecs.push_back(mk(16'h0099, 3'd2, 0, 1, 0, 3'd0, 5'd16));
        vecs.push_back(mk(16'h0099, 3'd0, 1, 0, 0, 3'd2, 5'd16));
        vecs.push_back(mk(16'h0010, 3'd0, 1, 0, 0, 3'd1, 5'd16));
        vecs.push_back(mk(16'h0005, 3'd0, 0, 1, 0, 3'd0, 5'd16));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d key=%0h st=%0d", i, vecs[i].key, vecs[i].st);
            do_lookup(vecs[i].key, vecs[i].st, tag, fl, lat);
            check({tag, " hit/miss/full/state_out"}, 32'(fl[7:2]),
                  32'({vecs[i].hit, vecs[i].miss, vecs[i].full, vecs[i].so}));
            check({tag, " occupancy"}, 32'(occupancy), 32'(vecs[i].occ));
            check({tag, " latency"}, lat, 2);
        end
        check("realloc_index4_key", 32'(dut.key_mem[4]), 32'h0099);

        // Hold request high after ack: only one lookup, ack stays high.
        @(negedge clk);
        lookup_req = 1'b1; lookup_key = 16'h0010; state_in = 3'd0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!lookup_ack && cnt < 20);
        check("hold_first_hit", 32'({lut_hit, lut_miss}), 32'b10);
        pulses = 0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (lut_hit || lut_miss) pulses++;
            if (lookup_ack) cnt++;
        end
        check("hold_extra_pulses", pulses, 0);
        check("hold_ack_cycles", cnt, 10);
        lookup_req = 1'b0;
        @(negedge clk);
        check("hold_ack_clear", 32'(lookup_ack), 32'd0);

        // Reset while the lookup sits in COMPARE.
        lookup_req = 1'b1; lookup_key = 16'h0001; state_in = 3'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        lookup_req = 1'b0;
        pulses = 32'(lookup_ack);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (lookup_ack) pulses++;
        end while (!ready && cnt < 40);
        check("midreset_ack_never", pulses, 0);
        check("midreset_sweep", cnt, 16);
        check("midreset_occupancy", 32'(occupancy), 32'd0);
        do_lookup(16'h0001, 3'd0, "midreset_relookup", fl, lat);
        check("midreset_key1_miss", 32'(fl[7:2]), 32'b010000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
